// File: rtl/ms_stopwatch_pkg.sv
// ============================================================================
// Module  : sw_pkg
// Brief   : Shared state encoding and digit limits for the ms_stopwatch block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sw_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_t;

   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam int         NUM_DIGITS   = 7;

   // Digit order, least significant first: ms u/t/h, sec u/t, min u/t.
   function automatic logic [3:0] digit_max(input int idx, input logic [3:0] min_tens_max);
      logic [3:0] m;
      m = BCD_MAX;
      if (idx == 4) m = SEC_TENS_MAX;
      if (idx == 6) m = min_tens_max;
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ms_stopwatch_bcd_digit.sv
// ============================================================================
// Module  : bcd_digit
// Brief   : One decimal counter stage, 0..MAX, with ripple carry to the next.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit #(
   parameter logic [3:0] MAX = 4'd9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q,
   output logic       carry
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= 4'd0;
      end else if (inc) begin
         q <= (q == MAX) ? 4'd0 : q + 4'd1;
      end
   end

   assign carry = inc && (q == MAX);

endmodule

`default_nettype wire

// File: rtl/ms_stopwatch.sv
// ============================================================================
// Module  : ms_stopwatch
// Brief   : BCD MM:SS.mmm stopwatch on the 1 ms tick with run/pause/clear.
//           Optional lap snapshot enabled by defining STOPWATCH_LAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_stopwatch
   import sw_pkg::*;
#(
   parameter int MIN_TENS_MAX = 5,
   parameter bit WRAP         = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce1ms,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   output logic [11:0] disp_ms,
   output logic [7:0]  disp_sec,
   output logic [7:0]  disp_min,
   output logic        running,
   output logic        overflow,
   output logic        lap_hold
);

   sw_state_t                 r_state;
   sw_state_t                 w_state_nxt;
   logic                      r_overflow;
   logic [4*NUM_DIGITS-1:0]   w_live;
   logic [4*NUM_DIGITS-1:0]   w_disp;
   logic [NUM_DIGITS-1:0]     w_inc;
   logic [NUM_DIGITS-1:0]     w_carry;
   logic [NUM_DIGITS-1:0]     w_is_max;
   logic                      w_count_en;
   logic                      w_at_max;
   logic                      w_max_hit;
   logic                      w_inc0;

   assign w_count_en = (r_state == RUN) && ce1ms;
   assign w_at_max   = &w_is_max;
   assign w_max_hit  = w_count_en && w_at_max;
   // In saturate mode the first stage is held off so the maximum stays put.
   assign w_inc0     = w_count_en && (WRAP || !w_at_max);

   generate
      for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
         localparam logic [3:0] c_max = digit_max(i, MIN_TENS_MAX[3:0]);

         bcd_digit #(
            .MAX (c_max)
         ) u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear),
            .inc   (w_inc[i]),
            .q     (w_live[4*i +: 4]),
            .carry (w_carry[i])
         );

         assign w_is_max[i] = (w_live[4*i +: 4] == c_max);

         if (i == 0) begin : g_first
            assign w_inc[i] = w_inc0;
         end else begin : g_ripple
            assign w_inc[i] = w_carry[i-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (start_stop) w_state_nxt = RUN;
            RUN:     if (start_stop || (w_max_hit && !WRAP)) w_state_nxt = PAUSE;
            PAUSE:   if (start_stop) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_overflow <= 1'b0;
      end else if (w_max_hit) begin
         r_overflow <= 1'b1;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic                    r_lap_hold;
   logic [4*NUM_DIGITS-1:0] r_snap;

   // The snapshot takes the pre-edge count, so a tick in the same cycle lands only in the live count.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_lap_hold <= 1'b0;
         r_snap     <= '0;
      end else if (lap) begin
         if (r_state == RUN) begin
            r_lap_hold <= 1'b1;
            r_snap     <= w_live;
         end else begin
            r_lap_hold <= 1'b0;
         end
      end
   end

   assign w_disp   = r_lap_hold ? r_snap : w_live;
   assign lap_hold = r_lap_hold;

   logic w_unused_carry;
   assign w_unused_carry = w_carry[NUM_DIGITS-1];
`else
   assign w_disp   = w_live;
   assign lap_hold = 1'b0;

   logic w_unused_inputs;
   assign w_unused_inputs = lap ^ w_carry[NUM_DIGITS-1];
`endif

   assign disp_ms  = w_disp[11:0];
   assign disp_sec = w_disp[19:12];
   assign disp_min = w_disp[27:20];
   assign running  = (r_state == RUN);
   assign overflow = r_overflow;

endmodule

`default_nettype wire
